// File: rtl/bias_stream_loader.sv
// Streams per-lane bias words into a shadow bank and, on a swap command, commits
// the completed set to the active bank driving q while the previous set stays in use.
module bias_stream_loader #(
   parameter int unsigned N_adder_tree = 16,
   parameter int unsigned BW           = 18
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_start,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [BW-1:0]              s_data,
   input  logic                       s_last,
   input  logic                       swap,
   output logic                       busy,
   output logic                       full,
   output logic                       err_len,
   output logic [N_adder_tree*BW-1:0] q
);

   localparam int unsigned CntW = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
   localparam logic [CntW-1:0] LastLane = CntW'(N_adder_tree - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

   state_e                     state_q, state_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [N_adder_tree*BW-1:0] shadow_q, shadow_d;
   logic [N_adder_tree*BW-1:0] q_q, q_d;
   logic                       err_q, err_d;
   logic                       ready_q, ready_d;
   logic                       busy_q, busy_d;
   logic                       full_q, full_d;
   logic                       accept;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      q_d      = q_q;
      err_d    = err_q;
      accept   = s_valid && (state_q == StLoad);

      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d = StLoad;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         StLoad: begin
            if (accept) begin
               shadow_d[cnt_q*BW +: BW] = s_data;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastLane) begin
                  // An over-long set still fills every lane; the surplus is refused.
                  state_d = StFull;
                  if (!s_last) err_d = 1'b1;
               end else if (s_last) begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end
            end
         end
         StFull: begin
            // swap wins over a simultaneous load_start, which is simply dropped.
            if (swap) begin
               q_d     = shadow_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      ready_d = (state_d == StLoad);
      busy_d  = (state_d == StLoad);
      full_d  = (state_d == StFull);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         shadow_q <= '0;
         q_q      <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         q_q      <= q_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         full_q   <= full_d;
      end
   end

   assign s_ready = ready_q;
   assign busy    = busy_q;
   assign full    = full_q;
   assign err_len = err_q;
   assign q       = q_q;

endmodule
